// File: rtl/block1_channel_serializer.sv
// Block-1 channel serializer: buffers pooled pixels (8 channel words each) in a
// pixel FIFO and streams them out one channel word per ready/valid handshake.
module block1_channel_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNEL    = 8,
    parameter int WIDTH      = 28,
    parameter int HEIGHT     = 28,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [DATA_WIDTH-1:0] data_in_3,
    input  logic [DATA_WIDTH-1:0] data_in_4,
    input  logic [DATA_WIDTH-1:0] data_in_5,
    input  logic [DATA_WIDTH-1:0] data_in_6,
    input  logic [DATA_WIDTH-1:0] data_in_7,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [2:0]            channel_idx,
    output logic                  valid_out,
    output logic                  last_out,
    output logic                  done,
    output logic                  full,
    output logic                  overflow
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int FRAME = WIDTH * HEIGHT;
    localparam int PW    = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [PW-1:0] PIX_LAST  = PW'(FRAME - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH][CHANNEL];

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_d;
    logic [2:0]    chan_cnt_q, chan_cnt_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          done_q, done_d;

    logic          empty;
    logic          hs;
    logic          pop_now;
    logic          push;
    logic          drop;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;

    // A push is allowed into a full FIFO when the head pixel leaves in the same cycle.
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        rd_idx     = rd_ptr_q[AW-1:0];
        wr_idx     = wr_ptr_q[AW-1:0];
        hs         = !empty && ready_in;
        pop_now    = hs && (chan_cnt_q == 3'd7);
        push       = valid_in && (!full_q || pop_now);
        drop       = valid_in && full_q && !pop_now;
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop_now};
        count_d    = wr_ptr_d - rd_ptr_d;
        chan_cnt_d = hs ? chan_cnt_q + 3'd1 : chan_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        if (pop_now) begin
            pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PW'(1);
        end
        full_d     = (count_d == DEPTH_CNT);
        overflow_d = overflow_q || drop;
        done_d     = pop_now && (pix_cnt_q == PIX_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            chan_cnt_q <= '0;
            pix_cnt_q  <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            chan_cnt_q <= chan_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // Pixel storage carries no reset; stale contents are masked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_idx][0] <= data_in_0;
            mem_q[wr_idx][1] <= data_in_1;
            mem_q[wr_idx][2] <= data_in_2;
            mem_q[wr_idx][3] <= data_in_3;
            mem_q[wr_idx][4] <= data_in_4;
            mem_q[wr_idx][5] <= data_in_5;
            mem_q[wr_idx][6] <= data_in_6;
            mem_q[wr_idx][7] <= data_in_7;
        end
    end

    always_comb begin
        valid_out   = !empty;
        data_out    = empty ? '0 : mem_q[rd_idx][chan_cnt_q];
        channel_idx = empty ? 3'd0 : chan_cnt_q;
        last_out    = !empty && (chan_cnt_q == 3'd7) && (pix_cnt_q == PIX_LAST);
        done        = done_q;
        full        = full_q;
        overflow    = overflow_q;
    end

endmodule

// File: tb/tb_block1_channel_serializer.sv
// Directed bench for block1_channel_serializer, run with a 2x2 pooled frame so
// frame-end behaviour is reachable in a few pixels.
module tb_block1_channel_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b0;
    logic [31:0] din [8];
    logic [31:0] data_out;
    logic [2:0]  channel_idx;
    logic        valid_out, last_out, done, full, overflow;

    int vectors = 0;
    int miscompares = 0;

    block1_channel_serializer #(
        .DATA_WIDTH(32), .CHANNEL(8), .WIDTH(2), .HEIGHT(2), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
        .data_in_4(din[4]), .data_in_5(din[5]), .data_in_6(din[6]), .data_in_7(din[7]),
        .ready_in(ready_in), .data_out(data_out), .channel_idx(channel_idx),
        .valid_out(valid_out), .last_out(last_out), .done(done), .full(full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [31:0] base);
        for (int k = 0; k < 8; k++) din[k] = base + 32'(k);
    endtask

    function automatic logic [31:0] pbase(input logic [31:0] tag, input int p);
        return tag + 32'(p * 256);
    endfunction

    // Async reset: outputs must clear before any clock edge.
    task automatic do_reset();
        valid_in = 1'b0;
        ready_in = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_idx", 32'(channel_idx), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_last", 32'(last_out), 32'd0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) din[k] = '0;
        #3;

        // Reset state
        do_reset();

        // Single pixel, ready held high
        ready_in = 1'b1;
        set_pix(32'h3f800000);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("p1_valid", 32'(valid_out), 32'd1);
            chk("p1_data", data_out, 32'h3f800000 + 32'(i));
            chk("p1_idx", 32'(channel_idx), 32'(i));
            chk("p1_last", 32'(last_out), 32'd0);
            step();
        end
        chk("p1_empty_valid", 32'(valid_out), 32'd0);
        chk("p1_empty_data", data_out, 32'd0);

        // Same pixel with ready toggling: word held while ready is low
        do_reset();
        set_pix(32'h3f800000);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int c = 0; c < 15; c++) begin
            ready_in = (c % 2 == 0);
            chk("tog_valid", 32'(valid_out), 32'd1);
            chk("tog_data", data_out, 32'h3f800000 + 32'((c + 1) / 2));
            chk("tog_idx", 32'(channel_idx), 32'((c + 1) / 2));
            step();
        end
        chk("tog_empty", 32'(valid_out), 32'd0);

        // Overflow: 17 pixels into a 16-deep FIFO with ready low
        do_reset();
        for (int p = 0; p < 17; p++) begin
            set_pix(pbase(32'h10000000, p));
            valid_in = 1'b1;
            step();
            chk("ovf_full", 32'(full), 32'(p >= 15));
            chk("ovf_flag", 32'(overflow), 32'(p == 16));
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int n = 0; n < 128; n++) begin
            chk("ovf_drain_valid", 32'(valid_out), 32'd1);
            chk("ovf_drain_data", data_out, pbase(32'h10000000, n / 8) + 32'(n % 8));
            chk("ovf_drain_idx", 32'(channel_idx), 32'(n % 8));
            chk("ovf_drain_last", 32'(last_out), 32'((n % 8 == 7) && ((n / 8) % 4 == 3)));
            step();
        end
        chk("ovf_after_valid", 32'(valid_out), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_after_full", 32'(full), 32'd0);

        // Full FIFO with a push landing on the channel-7 handshake
        do_reset();
        for (int p = 0; p < 16; p++) begin
            set_pix(pbase(32'h20000000, p));
            valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        chk("coin_full", 32'(full), 32'd1);
        ready_in = 1'b1;
        for (int n = 0; n < 7; n++) step();
        chk("coin_idx7", 32'(channel_idx), 32'd7);
        chk("coin_data7", data_out, pbase(32'h20000000, 0) + 32'd7);
        set_pix(pbase(32'h20000000, 16));
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        chk("coin_ovf", 32'(overflow), 32'd0);
        chk("coin_full_after", 32'(full), 32'd1);
        for (int n = 0; n < 128; n++) begin
            chk("coin_drain_data", data_out, pbase(32'h20000000, 1 + n / 8) + 32'(n % 8));
            chk("coin_drain_idx", 32'(channel_idx), 32'(n % 8));
            step();
        end
        chk("coin_empty", 32'(valid_out), 32'd0);

        // 2x2 frame plus one pixel of the next frame, streamed back-to-back
        do_reset();
        ready_in = 1'b1;
        for (int c = 0; c < 42; c++) begin
            int k;
            k = c - 1;
            chk("frm_valid", 32'(valid_out), 32'((k >= 0) && (k < 40)));
            if ((k >= 0) && (k < 40)) begin
                chk("frm_data", data_out, pbase(32'h30000000, k / 8) + 32'(k % 8));
                chk("frm_idx", 32'(channel_idx), 32'(k % 8));
            end
            chk("frm_last", 32'(last_out), 32'(k == 31));
            chk("frm_done", 32'(done), 32'(k == 32));
            valid_in = (c < 5);
            set_pix(pbase(32'h30000000, c));
            step();
        end
        valid_in = 1'b0;

        // Reset mid-serialization with 3 pixels buffered
        do_reset();
        for (int p = 0; p < 3; p++) begin
            set_pix(pbase(32'h40000000, p));
            valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int n = 0; n < 3; n++) step();
        chk("mid_idx3", 32'(channel_idx), 32'd3);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        chk("mid_rst_data", data_out, 32'd0);
        chk("mid_rst_idx", 32'(channel_idx), 32'd0);
        chk("mid_rst_full", 32'(full), 32'd0);
        step();
        reset = 1'b0;
        chk("mid_post_valid", 32'(valid_out), 32'd0);
        set_pix(32'h50000000);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("mid_new_data", data_out, 32'h50000000 + 32'(i));
            chk("mid_new_idx", 32'(channel_idx), 32'(i));
            chk("mid_new_done", 32'(done), 32'd0);
            step();
        end
        chk("mid_no_stale", 32'(valid_out), 32'd0);
        chk("mid_no_done", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
